// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2,
    DROP    = 2'd3
  } arb_state_t;

  localparam logic [2:0] W_BYTE = 3'b000;
  localparam logic [2:0] W_HALF = 3'b001;
  localparam logic [2:0] W_WORD = 3'b010;

  localparam int unsigned StreakW = 4;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
module arb_streak_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [StreakW-1:0] MaxCount = StreakW'(MAX_STREAK);

  logic [StreakW-1:0] count_q, count_d;

  assign at_max = (count_q == MaxCount);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and the MEM stage;
// data wins unless fetch has been starved for MAX_STREAK grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          if_req_valid,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_req_ready,
  output logic          if_resp_valid,
  output logic [DW-1:0] if_resp_data,
  input  logic          flush,
  // data port
  input  logic          d_req_valid,
  input  logic          d_req_we,
  input  logic [2:0]    d_req_width,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_req_ready,
  output logic          d_resp_valid,
  output logic [DW-1:0] d_resp_rdata,
  // memory port
  output logic          mem_req_valid,
  output logic          mem_req_we,
  output logic [2:0]    mem_req_width,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_req_ready,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_data
);

  arb_state_t state_q, state_d;

  logic sel_d, sel_if;
  logic at_max;
  logic if_resp_fire, d_resp_fire;

  logic          if_resp_valid_q, d_resp_valid_q;
  logic [DW-1:0] if_resp_data_q, d_resp_rdata_q;

  // Grants are only made from IDLE, so a response cycle never overlaps a new grant.
  always_comb begin
    sel_d  = 1'b0;
    sel_if = 1'b0;
    if (state_q == IDLE) begin
      if (d_req_valid && !(at_max && if_req_valid)) begin
        sel_d = 1'b1;
      end else if (if_req_valid && !flush) begin
        sel_if = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_valid = sel_d | sel_if;
    mem_req_we    = sel_d ? d_req_we    : 1'b0;
    mem_req_width = sel_d ? d_req_width : W_WORD;
    mem_req_addr  = sel_d ? d_req_addr  : if_req_addr;
    mem_req_wdata = sel_d ? d_req_wdata : '0;
    d_req_ready   = sel_d  & mem_req_ready;
    if_req_ready  = sel_if & mem_req_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req_ready) begin
          state_d = WAIT_D;
        end else if (if_req_ready) begin
          state_d = WAIT_IF;
        end
      end
      WAIT_D: begin
        if (mem_resp_valid) state_d = IDLE;
      end
      WAIT_IF: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  arb_streak_counter #(
    .MAX_STREAK(MAX_STREAK)
  ) u_streak (
    .clk   (clk),
    .rst   (rst),
    .inc   (d_req_ready & if_req_valid),
    .clr   (if_req_ready),
    .at_max(at_max)
  );

  // A flush in the response cycle kills the fetch just like an earlier one.
  assign if_resp_fire = (state_q == WAIT_IF) && mem_resp_valid && !flush;
  assign d_resp_fire  = (state_q == WAIT_D) && mem_resp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_resp_valid_q <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      if_resp_data_q  <= '0;
      d_resp_rdata_q  <= '0;
    end else begin
      if_resp_valid_q <= if_resp_fire;
      d_resp_valid_q  <= d_resp_fire;
      if (if_resp_fire) if_resp_data_q <= mem_resp_data;
      if (d_resp_fire)  d_resp_rdata_q <= mem_resp_data;
    end
  end

  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_data  = if_resp_data_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_resp_rdata  = d_resp_rdata_q;

endmodule
